// File: rtl/axis_multibeat_headerizer_pkg.sv
// Shared types and sizing helpers for the AXIS multi-beat headerizer.
// FSM state encoding and header width / beat-count computation.
package axis_multibeat_headerizer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } st_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int hdr_width(
    input int en_d, input int en_i, input int en_u,
    input int dw,   input int iw,   input int uw);
    return 1 + ((en_d != 0) ? dw : 0)
             + ((en_i != 0) ? iw : 0)
             + ((en_u != 0) ? uw : 0);
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Full-throughput 2-entry AXIS skid buffer; all m_* outputs registered.
// Ports: s_* upstream data/keep/last/valid/ready, m_* downstream same.
module axis_reg_slice #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [DATA_WIDTH/8-1:0] s_keep,
  input  logic                    s_last,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [DATA_WIDTH/8-1:0] m_keep,
  output logic                    m_last,
  output logic                    m_valid,
  input  logic                    m_ready
);

  logic [DATA_WIDTH-1:0]   sk_data;
  logic [DATA_WIDTH/8-1:0] sk_keep;
  logic                    sk_last;
  logic                    sk_valid;

  // Ready depends only on skid occupancy, so it is a
  // registered signal and breaks the ready path.
  assign s_ready = !sk_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      sk_valid <= 1'b0;
    end else if (!sk_valid) begin
      if (!m_valid || m_ready) begin
        m_valid <= s_valid;
        m_data  <= s_data;
        m_keep  <= s_keep;
        m_last  <= s_last;
      end else if (s_valid) begin
        sk_valid <= 1'b1;
        sk_data  <= s_data;
        sk_keep  <= s_keep;
        sk_last  <= s_last;
      end
    end else if (m_ready) begin
      m_data   <= sk_data;
      m_keep   <= sk_keep;
      m_last   <= sk_last;
      sk_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_multibeat_headerizer.sv
// Prefixes each AXIS packet with header beat(s) carrying TDEST/TID/TUSER
// and first-beat TLAST. Ports: sides_* input stream, hdr_* output, pkt_count.
module axis_multibeat_headerizer
  import axis_multibeat_headerizer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 16,
  parameter int ID_WIDTH   = 16,
  parameter int USER_WIDTH = 8,
  parameter int EN_DEST    = 1,
  parameter int EN_ID      = 1,
  parameter int EN_USER    = 1,
  parameter int TLAST_HACK = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   sides_TDATA,
  input  logic [DATA_WIDTH/8-1:0] sides_TKEEP,
  input  logic                    sides_TLAST,
  input  logic                    sides_TVALID,
  output logic                    sides_TREADY,
  input  logic [DEST_WIDTH-1:0]   sides_TDEST,
  input  logic [ID_WIDTH-1:0]     sides_TID,
  input  logic [USER_WIDTH-1:0]   sides_TUSER,
  output logic [DATA_WIDTH-1:0]   hdr_TDATA,
  output logic [DATA_WIDTH/8-1:0] hdr_TKEEP,
  output logic                    hdr_TLAST,
  output logic                    hdr_TVALID,
  input  logic                    hdr_TREADY,
  output logic [31:0]             pkt_count
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int HDR_W = hdr_width(EN_DEST, EN_ID, EN_USER,
                                   DEST_WIDTH, ID_WIDTH, USER_WIDTH);
  localparam int HDR_BEATS = ceil_div(HDR_W, DATA_WIDTH);
  localparam int HDR_TOT = HDR_BEATS * DATA_WIDTH;
  localparam int BCW = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

  // Packed field offsets, LSB first; disabled fields take no space.
  localparam int USER_OFF = 0;
  localparam int ID_OFF   = USER_OFF + ((EN_USER != 0) ? USER_WIDTH : 0);
  localparam int DEST_OFF = ID_OFF + ((EN_ID != 0) ? ID_WIDTH : 0);
  localparam int LAST_OFF = DEST_OFF + ((EN_DEST != 0) ? DEST_WIDTH : 0);

  st_t                  st;
  logic [BCW-1:0]       beat_cnt;
  logic [HDR_TOT-1:0]   hdr_next;
  logic [HDR_TOT-1:0]   hdr_reg;
  logic [DATA_WIDTH-1:0] hdr_beat;

  logic                  core_valid;
  logic                  core_ready;
  logic [DATA_WIDTH-1:0] core_data;
  logic [KW-1:0]         core_keep;
  logic                  core_last;

  always_comb begin
    hdr_next = '0;
    if (EN_USER != 0)
      hdr_next |= HDR_TOT'(sides_TUSER) << USER_OFF;
    if (EN_ID != 0)
      hdr_next |= HDR_TOT'(sides_TID) << ID_OFF;
    if (EN_DEST != 0)
      hdr_next |= HDR_TOT'(sides_TDEST) << DEST_OFF;
    hdr_next |= HDR_TOT'(sides_TLAST) << LAST_OFF;
  end

  always_comb begin
    hdr_beat = '0;
    for (int k = 0; k < HDR_BEATS; k++)
      if (beat_cnt == BCW'(k))
        hdr_beat = hdr_reg[k*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    core_valid   = 1'b0;
    core_data    = '0;
    core_keep    = '0;
    core_last    = 1'b0;
    sides_TREADY = 1'b0;
    unique case (1'b1)
      (st == HDR): begin
        core_valid = 1'b1;
        core_data  = hdr_beat;
        core_keep  = '1;
      end
      (st == BODY): begin
        core_valid   = sides_TVALID;
        core_data    = sides_TDATA;
        core_keep    = sides_TKEEP;
        core_last    = (TLAST_HACK != 0) ? 1'b1 : sides_TLAST;
        sides_TREADY = core_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= IDLE;
      beat_cnt <= '0;
    end else begin
      unique case (st)
        IDLE: if (sides_TVALID) begin
          hdr_reg  <= hdr_next;
          beat_cnt <= '0;
          st       <= HDR;
        end
        HDR: if (core_ready) begin
          if (beat_cnt == BCW'(HDR_BEATS - 1)) begin
            beat_cnt <= '0;
            st       <= BODY;
          end else begin
            beat_cnt <= beat_cnt + BCW'(1);
          end
        end
        BODY: if (sides_TVALID && core_ready &&
                  ((TLAST_HACK != 0) || sides_TLAST))
          st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      pkt_count <= '0;
    else if (hdr_TVALID && hdr_TREADY && hdr_TLAST)
      pkt_count <= pkt_count + 32'd1;
  end

  axis_reg_slice #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_slice (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (core_data),
    .s_keep  (core_keep),
    .s_last  (core_last),
    .s_valid (core_valid),
    .s_ready (core_ready),
    .m_data  (hdr_TDATA),
    .m_keep  (hdr_TKEEP),
    .m_last  (hdr_TLAST),
    .m_valid (hdr_TVALID),
    .m_ready (hdr_TREADY)
  );

endmodule
